// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states
//   ADJ_THRESH  : digit value at/above which the +3 correction applies
//   ADJ_ADD     : correction added to a digit before each shift
//   BCD_DIG_W   : bits per BCD digit
//   min_digits(): smallest digit count able to hold 2^bin_w - 1
// ---------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_ADD    = 4'd3;
   localparam int         BCD_DIG_W  = 4;

   // Number of decimal digits in the largest unsigned value of bin_w bits.
   function automatic int min_digits(input int bin_w);
      longint v;
      int     d;
      v = (longint'(1) << bin_w) - 1;
      d = 0;
      while (v > 0) begin
         d = d + 1;
         v = v / 10;
      end
      if (d == 0) d = 1;
      return d;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational double-dabble correction for one BCD digit: values of 5
//   or more get +3 so the following left shift carries into the next digit.
//   din  : digit before correction
//   dout : corrected digit (4-bit wrap; never overflows for legal digits)
// ---------------------------------------------------------------------------
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bcd_conv_seq.sv
// ---------------------------------------------------------------------------
// bcd_conv_seq
//   Multi-cycle binary-to-BCD converter (shift-and-add-3), one binary bit
//   per enabled clock, with valid/ready handshakes on both sides.
//   clk, rst_n : clock, async active-low reset
//   g_n        : active-low enable; high pauses CONV and blanks bcd_out
//   in_valid / in_ready / bin_in    : operand handshake
//   out_valid / out_ready / bcd_out : result handshake, digit 0 in [3:0]
//   busy       : high while converting or holding a result
// ---------------------------------------------------------------------------
module bcd_conv_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        g_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [BIN_W-1:0]            bin_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BCD_DIG_W*DIGITS-1:0] bcd_out,
   output logic                        busy
);

   localparam int ACC_W = BCD_DIG_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if (BIN_W < 4 || BIN_W > 16) begin : g_bad_width
      $error("bcd_conv_seq: BIN_W=%0d outside 4..16", BIN_W);
   end
   if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("bcd_conv_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
   end

   state_t             state;
   logic [BIN_W-1:0]   bin_reg;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   result;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   adj_acc;
   logic [ACC_W-1:0]   next_acc;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (acc[d*BCD_DIG_W +: BCD_DIG_W]),
         .dout (adj_acc[d*BCD_DIG_W +: BCD_DIG_W])
      );
   end

   // Corrected digits shifted left one place, binary MSB entering bit 0.
   // The dropped top bit is always zero for a legal DIGITS.
   assign next_acc = ACC_W'({adj_acc, bin_reg[BIN_W-1]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bin_reg <= '0;
         acc     <= '0;
         result  <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               bin_reg <= bin_in;
               acc     <= '0;
               cnt     <= CNT_W'(BIN_W);
               state   <= CONV;
            end
            CONV: if (!g_n) begin
               acc     <= next_acc;
               bin_reg <= bin_reg << 1;
               cnt     <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  result <= next_acc;
                  state  <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Blanking overrides everything; otherwise show the live result in DONE
   // and the last completed result elsewhere.
   always_comb begin
      bcd_out = result;
      if (g_n)                bcd_out = '1;
      else if (state == DONE) bcd_out = acc;
   end

endmodule
